// File: rtl/board_input_debounce.sv
// Board pushbutton/switch conditioner: 2-flop synchronizer, polarity fix, tick-based debounce.
// Optional edge pulses and any_change are built only when BOARD_DEBOUNCE_EDGE_EN is defined.
module board_input_debounce #(
  parameter int             W              = 22,
  parameter int             TICK_CYCLES    = 50000,
  parameter int             DEBOUNCE_TICKS = 10,
  parameter logic [W-1:0]   INV_MASK       = W'(4'hF)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw_in,
  output logic [W-1:0] clean_out,
  output logic [W-1:0] rise_pulse,
  output logic [W-1:0] fall_pulse,
  output logic         any_change
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);

  logic [W-1:0]         s1, s2, cur;
  logic [W-1:0]         stb, stb_nxt;
  logic [PW-1:0]        pcnt;
  logic                 tick;
  logic [W-1:0][CW-1:0] cnt, cnt_nxt;

  assign cur       = s2 ^ INV_MASK;
  assign tick      = (pcnt == PCNT_LAST);
  assign clean_out = stb;

  // Synchronizer and free-running prescaler; only reset restarts the tick phase.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values (s2 gets the old s1).
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      pcnt <= '0;
    end else begin
      s1   <= raw_in;
      s2   <= s1;
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

  // Per-bit debounce: any cycle of agreement discards accumulated ticks.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned, which would infer a latch.
    stb_nxt = stb;
    cnt_nxt = cnt;
    for (int i = 0; i < W; i++) begin
      if (cur[i] == stb[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CNT_LAST) begin
          stb_nxt[i] = cur[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the counters are plain flops, not a RAM, so they are cleared by reset like any state.
    if (reset) begin
      stb <= '0;
      cnt <= '0;
    end else begin
      stb <= stb_nxt;
      cnt <= cnt_nxt;
    end
  end

`ifdef BOARD_DEBOUNCE_EDGE_EN
  logic [W-1:0] rise_q, fall_q;
  logic         any_q;

  // Pulses load on the same edge as stb, so they coincide with the clean_out change.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      rise_q <= stb_nxt & ~stb;
      fall_q <= ~stb_nxt & stb;
      any_q  <= |(rise_q | fall_q);
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = any_q;
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
  assign any_change = 1'b0;
`endif

endmodule

// File: tb/tb_board_input_debounce.sv
// Self-checking bench for board_input_debounce (W=4, TICK_CYCLES=4, DEBOUNCE_TICKS=3, INV_MASK=4'b0011).
// Pulse expectations follow BOARD_DEBOUNCE_EDGE_EN, so the bench suits either build.
module tb_board_input_debounce;

  localparam int          W    = 4;
  localparam int          TICK = 4;
  localparam int          DEB  = 3;
  localparam logic [W-1:0] INV = 4'b0011;
`ifdef BOARD_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] raw;
    int           hold;
    logic [W-1:0] clean;
    int           n_any;
  } step_t;

  typedef struct {
    int   bit_i;
    logic val;
    int   edge_e;
    int   c_e;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] clean_out, rise_pulse, fall_pulse;
  logic         any_change;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int rel_edge = 0;
  logic rst_q = 1'b1;
  bit   mon_en = 1'b0;
  int   any_cnt = 0;
  logic [W-1:0] exp_stb = '0;
  logic [W-1:0] prev_clean = '0;
  logic         prev_changed = 1'b0;
  logic [W-1:0] chg, exp_r, exp_f;
  exp_t         sb[$];
  exp_t         e;
  step_t        steps[8];

  board_input_debounce #(
    .W(W), .TICK_CYCLES(TICK), .DEBOUNCE_TICKS(DEB), .INV_MASK(INV)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .clean_out(clean_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_change(any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge bookkeeping: rel_edge is the first edge that samples reset low.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    rst_q  <= reset;
    if (reset) rel_edge <= edge_n + 2;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Third tick edge strictly after the edge at which cur takes its new value.
  function automatic int accept_edge(input int c);
    int ed = c;
    int n  = 0;
    while (n < DEB) begin
      ed++;
      if ((ed - rel_edge) % TICK == TICK - 1) n++;
    end
    return ed;
  endfunction

  task automatic expect_changes(input logic [W-1:0] new_cur, input int c);
    exp_t x;
    for (int i = 0; i < W; i++) begin
      if (new_cur[i] != exp_stb[i]) begin
        x.bit_i  = i;
        x.val    = new_cur[i];
        x.edge_e = accept_edge(c);
        x.c_e    = c;
        sb.push_back(x);
      end
    end
    exp_stb = new_cur;
  endtask

  // Monitor: pulses against observed clean_out edges, clean_out edges against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        check("reset_clean", 32'(clean_out), 32'd0);
        check("reset_rise", 32'(rise_pulse), 32'd0);
        check("reset_fall", 32'(fall_pulse), 32'd0);
        check("reset_any", 32'(any_change), 32'd0);
        prev_clean   = '0;
        prev_changed = 1'b0;
      end else begin
        chg   = clean_out ^ prev_clean;
        exp_r = EDGE_EN ? (clean_out & ~prev_clean) : '0;
        exp_f = EDGE_EN ? (~clean_out & prev_clean) : '0;
        check("rise_pulse", 32'(rise_pulse), 32'(exp_r));
        check("fall_pulse", 32'(fall_pulse), 32'(exp_f));
        check("any_change", 32'(any_change), 32'(EDGE_EN & prev_changed));
        if (any_change) any_cnt++;
        for (int i = 0; i < W; i++) begin
          if (chg[i]) begin
            check("change_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("change_bit", 32'(i), 32'(e.bit_i));
              check("change_val", 32'(clean_out[i]), 32'(e.val));
              check("change_edge", 32'(edge_n), 32'(e.edge_e));
              check("latency_window",
                    32'((edge_n - e.c_e >= (DEB-1)*TICK + 1) && (edge_n - e.c_e <= DEB*TICK)), 32'd1);
            end
          end
        end
        prev_clean   = clean_out;
        prev_changed = |chg;
      end
    end
  end

  initial begin
    steps[0] = '{raw: 4'b0011, hold: 50, clean: 4'b0000, n_any: 0};  // idle after reset
    steps[1] = '{raw: 4'b0010, hold: 30, clean: 4'b0001, n_any: 1};  // key0 press
    steps[2] = '{raw: 4'b0011, hold: 30, clean: 4'b0000, n_any: 1};  // key0 release
    steps[3] = '{raw: 4'b1111, hold: 30, clean: 4'b1100, n_any: 1};  // simultaneous rise
    steps[4] = '{raw: 4'b0011, hold: 30, clean: 4'b0000, n_any: 1};  // simultaneous fall
    steps[5] = '{raw: 4'b0100, hold: 30, clean: 4'b0111, n_any: 1};
    steps[6] = '{raw: 4'b1011, hold: 30, clean: 4'b1000, n_any: 1};  // mixed rise/fall, one edge
    steps[7] = '{raw: 4'b0011, hold: 30, clean: 4'b0000, n_any: 1};

    raw_in = 4'b0011;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (steps[s]) begin
      @(posedge clk);
      #1 raw_in = steps[s].raw;
      any_cnt = 0;
      expect_changes(steps[s].raw ^ INV, edge_n + 2);
      repeat (steps[s].hold) @(posedge clk);
      #1;
      check($sformatf("step%0d_clean", s), 32'(clean_out), 32'(steps[s].clean));
      check($sformatf("step%0d_any_count", s), 32'(any_cnt), 32'(EDGE_EN ? steps[s].n_any : 0));
    end

    // Bounce on raw[2]: 3-cycle runs never span enough ticks to be accepted.
    for (int j = 0; j < 14; j++) begin
      raw_in[2] = (j % 2 == 0);
      repeat (3) @(posedge clk);
      #1;
    end
    check("bounce_no_change", 32'(clean_out), 32'd0);
    raw_in[2] = 1'b1;
    expect_changes(raw_in ^ INV, edge_n + 2);
    repeat (25) @(posedge clk);
    #1 check("bounce_settled", 32'(clean_out), 32'b0100);

    // Reset one tick into a raw[3] debounce: all progress is lost.
    raw_in[3] = 1'b1;
    expect_changes(raw_in ^ INV, edge_n + 2);
    repeat (7) @(posedge clk);
    #1 check("mid_debounce_not_yet", 32'(clean_out), 32'b0100);
    reset = 1'b1;
    sb.delete();
    exp_stb = '0;
    repeat (3) @(posedge clk);
    #1 check("mid_reset_clean", 32'(clean_out), 32'd0);
    reset = 1'b0;
    expect_changes(raw_in ^ INV, edge_n + 2);
    repeat (25) @(posedge clk);
    #1 check("post_reset_clean", 32'(clean_out), 32'b1100);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
